// File: rtl/mu_stage_pkg.sv
// Shared definitions for the iterative multiply stage: word/product buses,
// FSM encoding and the operand magnitude helper.
package mu_stage_pkg;
  localparam int WORD_DATA_W  = 32;
  localparam int DWORD_DATA_W = 2 * WORD_DATA_W;
  localparam int CNT_W        = 5;

  typedef logic [WORD_DATA_W-1:0]  word_data_t;
  typedef logic [DWORD_DATA_W-1:0] dword_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mu_state_e;

  // Unsigned magnitude; |-2^31| = 2^31 is exact in 32 unsigned bits.
  function automatic word_data_t mag(input word_data_t v);
    return v[WORD_DATA_W-1] ? (~v + word_data_t'(1)) : v;
  endfunction
endpackage

// File: rtl/mu_core.sv
// Radix-2 shift-add datapath: one multiplier bit per step, 32 steps per product.
module mu_core
  import mu_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [WORD_DATA_W-1:0]  mcand_i,
  input  logic [WORD_DATA_W-1:0]  mplier_i,
  output logic [DWORD_DATA_W-1:0] prod_o,
  output logic                    last_o
);
  logic [WORD_DATA_W-1:0]  mcand_q;
  logic [WORD_DATA_W-1:0]  mplier_q;
  logic [DWORD_DATA_W-1:0] prod_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WORD_DATA_W:0]    sum_d;
  logic [DWORD_DATA_W-1:0] prod_d;

  // Add into the upper half, then shift the whole partial product right.
  always_comb begin
    sum_d  = {1'b0, prod_q[DWORD_DATA_W-1:WORD_DATA_W]}
           + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum_d, prod_q[WORD_DATA_W-1:1]};
  end

  // The stage captures the next value on the wrapping step, so expose prod_d.
  assign prod_o = prod_d;
  assign last_o = step_i && (cnt_q == CNT_W'(WORD_DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      prod_q   <= prod_d;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mu_stage.sv
// Signed 32x32 iterative multiply stage with valid/ready intake and a one-cycle
// result pulse for the downstream accumulator.
module mu_stage
  import mu_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [WORD_DATA_W-1:0] x_in,
  input  logic [WORD_DATA_W-1:0] w_in,
  output logic [WORD_DATA_W-1:0] mu_out,
  output logic                   mu_rdy,
  output logic                   mu_off
);
  mu_state_e              state_q;
  logic                   sign_q;
  logic [WORD_DATA_W-1:0] mu_out_q;
  logic                   mu_off_q;
  logic                   mu_rdy_q;

  logic                    accept_d;
  logic                    last_d;
  logic [DWORD_DATA_W-1:0] prod_d;
  logic [DWORD_DATA_W-1:0] res_d;

  function automatic dword_data_t fix_sign(input dword_data_t m, input logic neg);
    return neg ? (~m + dword_data_t'(1)) : m;
  endfunction

  // Overflow when bits [63:31] are not a pure sign extension.
  function automatic logic word_ovf(input dword_data_t r);
    logic [WORD_DATA_W:0] hi;
    hi = r[DWORD_DATA_W-1:WORD_DATA_W-1];
    return !((&hi) || !(|hi));
  endfunction

  assign in_rdy   = (state_q != CALC);
  assign accept_d = in_vld && in_rdy;
  assign res_d    = fix_sign(prod_d, sign_q);

  mu_core u_core (
    .clk      (clk),
    .rst      (reset),
    .load_i   (accept_d),
    .step_i   (state_q == CALC),
    .mcand_i  (mag(x_in)),
    .mplier_i (mag(w_in)),
    .prod_o   (prod_d),
    .last_o   (last_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mu_out_q <= '0;
      mu_off_q <= 1'b0;
      mu_rdy_q <= 1'b0;
    end else begin
      mu_rdy_q <= 1'b0;
      case (state_q)
        IDLE: if (accept_d) begin
          sign_q  <= x_in[WORD_DATA_W-1] ^ w_in[WORD_DATA_W-1];
          state_q <= CALC;
        end
        CALC: if (last_d) begin
          mu_out_q <= res_d[WORD_DATA_W-1:0];
          mu_off_q <= word_ovf(res_d);
          mu_rdy_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: if (accept_d) begin
          sign_q  <= x_in[WORD_DATA_W-1] ^ w_in[WORD_DATA_W-1];
          state_q <= CALC;
        end else begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mu_out = mu_out_q;
  assign mu_off = mu_off_q;
  assign mu_rdy = mu_rdy_q;
endmodule
